enc_cnt_capture: RTL
====================

// Module: enc_cnt_capture
// PURPOSE
//  Downstream stage of the encoder counter top level. Takes a trigger-synchronous snapshot of both 64-bit
//  encoder counts (A0, A1) plus a free-running timestamp, queues the snapshots in a FIFO and hands them
//  to DAQ readout over a valid/ready interface. It flags and counts snapshots lost to a full FIFO.
// PARAMETERS
//  CNT_W   64  width of each encoder count input/output
//  TS_W    32  width of timestamp counter
//  DEPTH   16  FIFO entries; power of 2, >=2
//  DROP_W  16  width of dropped-snapshot counter
// PORTS
//  CLK        in   1      system clock, all logic rising-edge
//  I_RST      in   1      synchronous reset, active-high
//  I_ARM      in   1      capture enable (same arm signal as counters)
//  I_TRIG     in   1      capture trigger, CLK-synchronous level; rising edge = capture request
//  I_CNT_A0   in   CNT_W  encoder 0 count from counter stage
//  I_CNT_A1   in   CNT_W  encoder 1 count from counter stage
//  I_READY    in   1      readout accepts head entry
//  O_VALID    out  1      head entry valid
//  O_TS       out  TS_W   head entry timestamp
//  O_CNT_A0   out  CNT_W  head entry count 0
//  O_CNT_A1   out  CNT_W  head entry count 1
//  O_LEVEL    out  log2(DEPTH)+1  entries currently stored
//  O_OVF      out  1      sticky: >=1 snapshot dropped since last arm/reset
//  O_DROP_CNT out  DROP_W dropped snapshots, saturating
// BEHAVIOUR
//  Reset (I_RST=1 at edge): FIFO empty, O_VALID=0, O_TS/O_CNT_A0/O_CNT_A1=0, O_LEVEL=0, O_OVF=0,
//   O_DROP_CNT=0, timestamp=0, trig history reg=0, arm history reg=0. Reset wins over all other events.
//  States: IDLE (I_ARM=0) / ARMED (I_ARM=1), tracked by registered r_arm.
//  IDLE->ARMED (I_ARM=1, r_arm=0): flush FIFO, timestamp=0, O_OVF=0, O_DROP_CNT=0; no capture that cycle.
//  ARMED->IDLE: captures stop; timestamp holds; stored entries stay readable.
//  Timestamp: +1 every cycle while ARMED, wraps 2^TS_W-1 -> 0 silently.
//  Trigger edge: trig_rise = I_TRIG & ~r_trig; r_trig <= I_TRIG every cycle (also when IDLE).
//  Capture: edge n with trig_rise & ARMED (not arm-entry cycle) writes {timestamp, I_CNT_A0, I_CNT_A1}
//   as sampled at edge n. Level held high = one capture only.
//  Latency: entry written at edge n into empty FIFO -> O_VALID=1 and data on outputs after edge n.
//  Pop: O_VALID & I_READY at an edge removes head; next entry (if any) appears after that same edge.
//  Outputs driven from head storage; hold stable while O_VALID=1 & I_READY=0.
//  O_VALID=0 -> data outputs hold last popped values (don't care for readout).
//  Full (O_LEVEL=DEPTH): capture with no pop is dropped: O_OVF<=1, O_DROP_CNT+1, saturates at 2^DROP_W-1.
//  Full + capture + pop same edge: both performed, no drop, O_LEVEL stays DEPTH.
//  Empty + capture + I_READY=1: no pop (O_VALID=0 at that edge); entry stored, O_LEVEL=1.
//  O_LEVEL updated same edge as push/pop; pointers wrap modulo DEPTH.
//  Reset mid-operation: all stored entries discarded, returns to reset values next cycle.
// TESTING
//  1 Reset, arm, hold I_READY=0, CNT_A0=0x10/CNT_A1=0x20, pulse TRIG 5 cycles after arm
//    -> O_VALID=1 next cycle, O_TS=5, O_CNT_A0=0x10, O_CNT_A1=0x20, O_LEVEL=1.
//  2 DEPTH=16, I_READY=0, 18 single-cycle triggers -> O_LEVEL=16, O_OVF=1, O_DROP_CNT=2;
//    then I_READY=1 -> 16 entries out in capture order, O_LEVEL=0, O_VALID=0.
//  3 FIFO full, trigger on same edge as pop -> O_DROP_CNT unchanged, O_LEVEL=16, new entry read out last.
//  4 I_TRIG held high 20 cycles -> exactly 1 entry; TRIG while I_ARM=0 -> no entry.
//  5 Fill 3 entries, drop I_ARM then re-raise it -> FIFO flushed (O_VALID=0, O_LEVEL=0), O_OVF=0,
//    timestamp restarts at 0; I_RST mid-readout -> all outputs 0 next cycle.
//  6 Force timestamp near 2^32-1 (TS_W=8 variant: 255) -> capture after wrap shows O_TS=0, 1, ...

Source files
------------

// File: rtl/enc_cnt_capture.sv
// rtl/enc_cnt_capture.sv - trigger-synchronous snapshot of two encoder counts plus timestamp, queued in a FIFO for readout
module enc_cnt_capture #(
    parameter int CNT_W  = 64,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              CLK,
    input  logic              I_RST,
    input  logic              I_ARM,
    input  logic              I_TRIG,
    input  logic [CNT_W-1:0]  I_CNT_A0,
    input  logic [CNT_W-1:0]  I_CNT_A1,
    input  logic              I_READY,
    output logic              O_VALID,
    output logic [TS_W-1:0]   O_TS,
    output logic [CNT_W-1:0]  O_CNT_A0,
    output logic [CNT_W-1:0]  O_CNT_A1,
    output logic [LW-1:0]     O_LEVEL,
    output logic              O_OVF,
    output logic [DROP_W-1:0] O_DROP_CNT
);
    localparam int EW = TS_W + 2 * CNT_W;

    logic [EW-1:0]     mem [DEPTH];

    logic              arm_q, arm_d;
    logic              trig_q, trig_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [LW-1:0]     level_q, level_d;
    logic              valid_q, valid_d;
    logic [EW-1:0]     head_q, head_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              arm_entry, armed, trig_rise, capture, full, pop, push, drop;
    logic [EW-1:0]     push_data;

    always_comb begin
        arm_entry = I_ARM & ~arm_q;
        armed     = I_ARM & arm_q;
        trig_rise = I_TRIG & ~trig_q;
        capture   = trig_rise & armed;
        full      = (level_q == LW'(DEPTH));
        pop       = valid_q & I_READY;
        push      = capture & (~full | pop);
        drop      = capture & full & ~pop;
        push_data = {ts_q, I_CNT_A0, I_CNT_A1};

        arm_d   = I_ARM;
        trig_d  = I_TRIG;
        ts_d    = ts_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        valid_d = valid_q;
        head_d  = head_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        if (arm_entry) begin
            ts_d    = '0;
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            drop_d  = '0;
        end else begin
            if (armed)
                ts_d = ts_q + 1'b1;
            if (push)
                wr_d = wr_q + 1'b1;
            if (pop)
                rd_d = rd_q + 1'b1;
            level_d = level_q + LW'(push) - LW'(pop);
            valid_d = (level_d != '0);
            // The pushed word becomes head when nothing older survives this edge
            if (valid_d) begin
                if (push && (level_q == LW'(pop)))
                    head_d = push_data;
                else
                    head_d = mem[rd_d];
            end
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1)
                    drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (I_RST) begin
            arm_q   <= 1'b0;
            trig_q  <= 1'b0;
            ts_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            arm_q   <= arm_d;
            trig_q  <= trig_d;
            ts_q    <= ts_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!I_RST && push)
            mem[wr_q] <= push_data;
    end

    assign O_VALID    = valid_q;
    assign O_TS       = head_q[EW-1 -: TS_W];
    assign O_CNT_A0   = head_q[2*CNT_W-1 -: CNT_W];
    assign O_CNT_A1   = head_q[CNT_W-1:0];
    assign O_LEVEL    = level_q;
    assign O_OVF      = ovf_q;
    assign O_DROP_CNT = drop_q;
endmodule
